// File: rtl/xadc_drp_responder.sv
// Stand-in for the XADC primitive: an auxiliary-channel sequencer (VAUX6/7/14/15)
// plus a fixed-latency DRP register responder.
module xadc_drp_responder #(
  parameter int unsigned CONV_CYCLES = 26,
  parameter int unsigned DRP_LATENCY = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        busy_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  input  logic [47:0] ch_code_in,
  output logic        drp_err_out
);

  localparam int unsigned CW = $clog2(CONV_CYCLES);
  localparam int unsigned DW = $clog2(DRP_LATENCY + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [DW-1:0] DRP_INIT  = DW'(DRP_LATENCY);

  localparam logic [6:0]  ADDR_VAUX6  = 7'h16;
  localparam logic [6:0]  ADDR_VAUX7  = 7'h17;
  localparam logic [6:0]  ADDR_VAUX14 = 7'h1E;
  localparam logic [6:0]  ADDR_VAUX15 = 7'h1F;
  localparam logic [6:0]  ADDR_MASK   = 7'h49;
  localparam logic [15:0] MASK_BITS   = 16'hC0C0;

  typedef enum logic {SEQ_IDLE, SEQ_CONVERT} seq_state_e;
  typedef enum logic {D_IDLE, D_WAIT} drp_state_e;

  // Sequencer state
  seq_state_e      seq_state_q, seq_state_d;
  logic [CW-1:0]   conv_cnt_q, conv_cnt_d;
  logic [1:0]      cur_idx_q, cur_idx_d;
  logic [4:0]      chan_q, chan_d;
  logic            eoc_q, eoc_d;
  logic            busy_q, busy_d;
  logic [15:0]     res_q [4];
  logic [15:0]     res_d [4];

  // DRP state
  drp_state_e      drp_state_q, drp_state_d;
  logic [DW-1:0]   drp_cnt_q, drp_cnt_d;
  logic [6:0]      addr_q, addr_d;
  logic            we_q, we_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     mask_q, mask_d;
  logic [15:0]     do_q, do_d;
  logic            drdy_q, drdy_d;
  logic            err_q, err_d;

  logic [3:0]      chan_en;
  logic [1:0]      idle_start;
  logic [11:0]     code_sel;
  logic [15:0]     rd_mux;

  // First enabled slot at or after 'start' in the order 6,7,14,15 with wrap
  function automatic logic [1:0] pick_next(input logic [3:0] en, input logic [1:0] start);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && en[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [1:0] idx_of(input logic [4:0] ch);
    case (ch)
      5'h17:   return 2'd1;
      5'h1E:   return 2'd2;
      5'h1F:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [4:0] chan_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 5'h16;
      2'd1:    return 5'h17;
      2'd2:    return 5'h1E;
      default: return 5'h1F;
    endcase
  endfunction

  assign chan_en    = {mask_q[15], mask_q[14], mask_q[7], mask_q[6]};
  assign idle_start = (chan_q == 5'd0) ? 2'd0 : idx_of(chan_q) + 2'd1;

  always_comb begin
    code_sel = ch_code_in[11:0];
    case (cur_idx_q)
      2'd0:    code_sel = ch_code_in[11:0];
      2'd1:    code_sel = ch_code_in[23:12];
      2'd2:    code_sel = ch_code_in[35:24];
      default: code_sel = ch_code_in[47:36];
    endcase
  end

  // Sequencer next state
  always_comb begin
    seq_state_d = seq_state_q;
    conv_cnt_d  = conv_cnt_q;
    cur_idx_d   = cur_idx_q;
    chan_d      = chan_q;
    eoc_d       = 1'b0;
    for (int i = 0; i < 4; i++) res_d[i] = res_q[i];
    case (seq_state_q)
      SEQ_IDLE: begin
        if (|chan_en) begin
          seq_state_d = SEQ_CONVERT;
          cur_idx_d   = pick_next(chan_en, idle_start);
          conv_cnt_d  = '0;
        end
      end
      SEQ_CONVERT: begin
        if (conv_cnt_q == CONV_LAST) begin
          res_d[cur_idx_q] = {code_sel, 4'b0000};
          chan_d           = chan_of(cur_idx_q);
          eoc_d            = 1'b1;
          if (|chan_en) begin
            cur_idx_d  = pick_next(chan_en, cur_idx_q + 2'd1);
            conv_cnt_d = '0;
          end else begin
            seq_state_d = SEQ_IDLE;
          end
        end else begin
          conv_cnt_d = conv_cnt_q + CW'(1);
        end
      end
      default: seq_state_d = SEQ_IDLE;
    endcase
    busy_d = (seq_state_d == SEQ_CONVERT);
  end

  // Register contents as seen before the drdy edge
  always_comb begin
    case (addr_q)
      ADDR_VAUX6:  rd_mux = res_q[0];
      ADDR_VAUX7:  rd_mux = res_q[1];
      ADDR_VAUX14: rd_mux = res_q[2];
      ADDR_VAUX15: rd_mux = res_q[3];
      ADDR_MASK:   rd_mux = mask_q;
      default:     rd_mux = 16'h0000;
    endcase
  end

  // DRP next state; a request during the wait or the drdy cycle is dropped and flagged
  always_comb begin
    drp_state_d = drp_state_q;
    drp_cnt_d   = drp_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    do_d        = do_q;
    drdy_d      = 1'b0;
    err_d       = err_q;
    case (drp_state_q)
      D_IDLE: begin
        if (den_in) begin
          if (drdy_q) begin
            err_d = 1'b1;
          end else begin
            addr_d      = daddr_in;
            we_d        = dwe_in;
            wdata_d     = di_in;
            drp_cnt_d   = DRP_INIT;
            drp_state_d = D_WAIT;
          end
        end
      end
      D_WAIT: begin
        if (den_in) err_d = 1'b1;
        if (drp_cnt_q == '0) begin
          drdy_d      = 1'b1;
          drp_state_d = D_IDLE;
          if (we_q) begin
            do_d = 16'h0000;
            if (addr_q == ADDR_MASK) mask_d = wdata_q & MASK_BITS;
          end else begin
            do_d = rd_mux;
          end
        end else begin
          drp_cnt_d = drp_cnt_q - DW'(1);
        end
      end
      default: drp_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      seq_state_q <= SEQ_IDLE;
      conv_cnt_q  <= '0;
      cur_idx_q   <= '0;
      chan_q      <= '0;
      eoc_q       <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
      drp_state_q <= D_IDLE;
      drp_cnt_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= MASK_BITS;
      do_q        <= '0;
      drdy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      seq_state_q <= seq_state_d;
      conv_cnt_q  <= conv_cnt_d;
      cur_idx_q   <= cur_idx_d;
      chan_q      <= chan_d;
      eoc_q       <= eoc_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
      drp_state_q <= drp_state_d;
      drp_cnt_q   <= drp_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      do_q        <= do_d;
      drdy_q      <= drdy_d;
      err_q       <= err_d;
    end
  end

  assign do_out      = do_q;
  assign drdy_out    = drdy_q;
  assign busy_out    = busy_q;
  assign eoc_out     = eoc_q;
  assign channel_out = chan_q;
  assign drp_err_out = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: channel sequencing, DRP reads/writes,
// mask changes, protocol errors and asynchronous reset.
module tb_xadc_drp_responder;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  daddr = '0;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [15:0] di = '0;
  logic [15:0] do_out;
  logic        drdy, busy, eoc, err;
  logic [4:0]  channel;
  logic [47:0] ch_code = {12'h5A5, 12'hABC, 12'h123, 12'h0FF};

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];
  logic [4:0]  ch_q [$];

  xadc_drp_responder #(.CONV_CYCLES(26), .DRP_LATENCY(4)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .daddr_in    (daddr),
    .den_in      (den),
    .dwe_in      (dwe),
    .di_in       (di),
    .do_out      (do_out),
    .drdy_out    (drdy),
    .busy_out    (busy),
    .eoc_out     (eoc),
    .channel_out (channel),
    .ch_code_in  (ch_code),
    .drp_err_out (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // One DRP request; returns data and edges from the accept edge to drdy
  task automatic drp_xfer(input logic [6:0] a, input logic w, input logic [15:0] d,
                          output logic [15:0] rd, output int lat, output bit ok);
    @(negedge clk);
    daddr = a; dwe = w; di = d; den = 1'b1;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    ok = 1'b0; lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (drdy) begin
        ok = 1'b1; lat = i; rd = do_out;
        break;
      end
    end
  endtask

  task automatic wait_eoc(input int limit, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (eoc) begin
        got = 1'b1; cyc = i;
        break;
      end
    end
  endtask

  task automatic count_drdy(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (drdy) cnt++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] rd, e; int lat; bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({do_out, drdy, busy, eoc, channel, err} !== 25'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: do=%h drdy=%b busy=%b eoc=%b ch=%h err=%b, required all 0",
               do_out, drdy, busy, eoc, channel, err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_after_reset: got %b, required 1", busy);
    end
    exp_q.push_back(16'hC0C0);
    drp_xfer(7'h49, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e || lat != LAT) begin
      n_bad++; $display("FAIL reset_mask: do=%h lat=%0d ok=%0d, required %h lat %0d", rd, lat, ok, e, LAT);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] rd, e; int lat, cyc, ecyc; bit ok, got; logic [4:0] ec;
    logic [6:0]  ta [7];
    logic        tw [7];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ch_q.push_back(5'h16); ch_q.push_back(5'h17); ch_q.push_back(5'h1E);
    ch_q.push_back(5'h1F); ch_q.push_back(5'h16);
    for (int n = 0; n < 5; n++) begin
      wait_eoc(60, got, cyc);
      ec = ch_q.pop_front(); ecyc = (n == 0) ? 27 : 26; n_cmp++;
      if (!got || channel !== ec || cyc != ecyc) begin
        n_bad++; $display("FAIL seq_eoc%0d: got=%0d ch=%h cyc=%0d, required ch %h cyc %0d", n, got, channel, cyc, ec, ecyc);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (eoc !== 1'b0) begin
      n_bad++; $display("FAIL eoc_width: eoc=%b one cycle after pulse, required 0", eoc);
    end
    ta = '{7'h1E, 7'h16, 7'h1F, 7'h17, 7'h00, 7'h16, 7'h16};
    tw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(16'hABC0); exp_q.push_back(16'h0FF0); exp_q.push_back(16'h5A50);
    exp_q.push_back(16'h1230); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0FF0);
    for (int n = 0; n < 7; n++) begin
      drp_xfer(ta[n], tw[n], 16'hFFFF, rd, lat, ok);
      e = exp_q.pop_front(); n_cmp++;
      if (!ok || rd !== e || lat != LAT) begin
        n_bad++; $display("FAIL result_rd%0d addr %h: do=%h lat=%0d ok=%0d, required %h lat %0d", n, ta[n], rd, lat, ok, e, LAT);
      end
    end
  endtask

  task automatic test_mask_single();
    logic [15:0] rd, e; int lat, cyc; bit ok, got; logic [4:0] ec;
    for (int n = 0; n < 6; n++) begin
      wait_eoc(60, got, cyc);
      if (channel == 5'h1F) break;
    end
    n_cmp++;
    if (channel !== 5'h1F) begin
      n_bad++; $display("FAIL find_vaux15: ch=%h, required 1f", channel);
    end
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0080);
    drp_xfer(7'h49, 1'b1, 16'h3F80, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL mask_wr: do=%h ok=%0d, required %h", rd, ok, e);
    end
    drp_xfer(7'h49, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL mask_rd: do=%h ok=%0d, required %h", rd, ok, e);
    end
    ch_q.push_back(5'h16); ch_q.push_back(5'h17); ch_q.push_back(5'h17); ch_q.push_back(5'h17);
    for (int n = 0; n < 4; n++) begin
      wait_eoc(60, got, cyc);
      ec = ch_q.pop_front(); n_cmp++;
      if (!got || channel !== ec || (n > 0 && cyc != 26)) begin
        n_bad++; $display("FAIL single_eoc%0d: got=%0d ch=%h cyc=%0d, required ch %h", n, got, channel, cyc, ec);
      end
    end
  endtask

  task automatic test_mask_empty();
    logic [15:0] rd, e; int lat, cyc; bit ok, got;
    exp_q.push_back(16'h0000);
    drp_xfer(7'h49, 1'b1, 16'h0000, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL clear_wr: do=%h ok=%0d, required %h", rd, ok, e);
    end
    wait_eoc(60, got, cyc);
    n_cmp++;
    if (!got || channel !== 5'h17 || busy !== 1'b0) begin
      n_bad++; $display("FAIL last_eoc: got=%0d ch=%h busy=%b, required ch 17 busy 0", got, channel, busy);
    end
    wait_eoc(100, got, cyc);
    n_cmp++;
    if (got || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_eoc: eoc=%0d busy=%b, required none and busy 0", got, busy);
    end
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    drp_xfer(7'h49, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL clear_rd: do=%h ok=%0d, required %h", rd, ok, e);
    end
    drp_xfer(7'h49, 1'b1, 16'hC0C0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL restore_wr: do=%h ok=%0d, required %h", rd, ok, e);
    end
    wait_eoc(60, got, cyc);
    n_cmp++;
    if (!got || channel !== 5'h1E || cyc != 27) begin
      n_bad++; $display("FAIL restart_eoc: got=%0d ch=%h cyc=%0d, required ch 1e cyc 27", got, channel, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, e; int lat, cnt; bit ok;
    exp_q.push_back(16'hC0C0); exp_q.push_back(16'hABC0);
    drp_xfer(7'h49, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e || lat != LAT) begin
      n_bad++; $display("FAIL b2b_first: do=%h lat=%0d ok=%0d, required %h", rd, lat, ok, e);
    end
    drp_xfer(7'h1E, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e || lat != LAT || err !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second: do=%h lat=%0d ok=%0d err=%b, required %h err 0", rd, lat, ok, err, e);
    end
    daddr = 7'h16; den = 1'b1;
    @(negedge clk);
    den = 1'b0;
    count_drdy(15, cnt);
    n_cmp++;
    if (cnt != 0 || err !== 1'b1 || do_out !== 16'hABC0) begin
      n_bad++; $display("FAIL den_in_drdy: drdy count=%0d err=%b do=%h, required 0, 1, abc0", cnt, err, do_out);
    end
  endtask

  task automatic test_drp_err();
    logic [15:0] e; int cnt, lat; logic [15:0] first;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'hC0C0);
    daddr = 7'h49; dwe = 1'b0; den = 1'b1;
    @(negedge clk); den = 1'b0;
    @(negedge clk); daddr = 7'h16; den = 1'b1;
    @(negedge clk); den = 1'b0;
    cnt = 0; lat = 0; first = '0;
    for (int i = 3; i <= 25; i++) begin
      @(negedge clk);
      if (drdy) begin
        if (cnt == 0) begin lat = i; first = do_out; end
        cnt++;
      end
    end
    e = exp_q.pop_front(); n_cmp++;
    if (cnt != 1 || first !== e || lat != LAT || err !== 1'b1) begin
      n_bad++; $display("FAIL overlap_den: drdy count=%0d do=%h lat=%0d err=%b, required 1, %h, %0d, 1", cnt, first, lat, err, e, LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd, e; int lat, cnt; bit ok;
    exp_q.push_back(16'h0000);
    drp_xfer(7'h49, 1'b1, 16'h4040, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL pre_wr: do=%h ok=%0d, required %h", rd, ok, e);
    end
    daddr = 7'h49; den = 1'b1;
    @(negedge clk); den = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: busy=%b err=%b, required 1 1", busy, err);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({do_out, drdy, busy, eoc, channel, err} !== 25'h0) begin
      n_bad++; $display("FAIL async_reset: do=%h drdy=%b busy=%b eoc=%b ch=%h err=%b, required all 0",
                        do_out, drdy, busy, eoc, channel, err);
    end
    @(negedge clk);
    rst = 1'b0;
    count_drdy(15, cnt);
    n_cmp++;
    if (cnt != 0) begin
      n_bad++; $display("FAIL dropped_txn: drdy count=%0d, required 0", cnt);
    end
    exp_q.push_back(16'hC0C0);
    drp_xfer(7'h49, 1'b0, 16'h0, rd, lat, ok);
    e = exp_q.pop_front(); n_cmp++;
    if (!ok || rd !== e) begin
      n_bad++; $display("FAIL mask_after_reset: do=%h ok=%0d, required %h", rd, ok, e);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_mask_single();
    test_mask_empty();
    test_back_to_back();
    test_drp_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
